// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM states, sync marker and RAM word/address types.
// PROG_LOADER_CHECKSUM_EN adds the GET_SUM and ERROR states.
package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef logic [7:0]  addr_t;
    typedef logic [7:0]  len_t;
    typedef logic [15:0] word_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_GET_PC,
        S_GET_BASE,
        S_GET_LEN,
        S_GET_HI,
        S_GET_LO,
        S_WRITE,
        S_RUN
`ifdef PROG_LOADER_CHECKSUM_EN
        ,
        S_GET_SUM,
        S_ERROR
`endif
    } state_t;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader that writes a program into the CPU RAM and then releases the CPU.
// Define PROG_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte per frame.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        ram_wren,
    output addr_t       ram_addr,
    output word_t       ram_wrdata,
    output logic [7:0]  start_pc,
    output logic        cpu_rst_n,
    output logic        done,
    output logic        err
);

    state_t     state, state_next;
    addr_t      addr_cnt;
    len_t       word_cnt;
    logic [7:0] hi_byte;
    logic       accept;
    logic       is_sync;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t DATA_DONE = S_GET_SUM;
    logic [7:0] sum;
`else
    localparam state_t DATA_DONE = S_RUN;
`endif

    assign in_ready = !rst && (state != S_WRITE);
    assign accept   = in_valid && in_ready;
    assign is_sync  = accept && (in_data == SYNC_BYTE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (is_sync) state_next = S_GET_PC;
            S_GET_PC:   if (accept) state_next = S_GET_BASE;
            S_GET_BASE: if (accept) state_next = S_GET_LEN;
            S_GET_LEN:  if (accept) state_next = (in_data == 8'h00) ? DATA_DONE : S_GET_HI;
            S_GET_HI:   if (accept) state_next = S_GET_LO;
            S_GET_LO:   if (accept) state_next = S_WRITE;
            S_WRITE:    state_next = (word_cnt == 8'd1) ? DATA_DONE : S_GET_HI;
            S_RUN:      if (is_sync) state_next = S_GET_PC;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_GET_SUM:  if (accept) state_next = (in_data == sum) ? S_RUN : S_ERROR;
            S_ERROR:    if (is_sync) state_next = S_GET_PC;
`endif
            default:    state_next = S_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they track the state exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wren   <= 1'b0;
            ram_addr   <= '0;
            ram_wrdata <= '0;
            start_pc   <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            addr_cnt   <= '0;
            word_cnt   <= '0;
            hi_byte    <= '0;
        end else begin
            ram_wren  <= (state_next == S_WRITE);
            cpu_rst_n <= (state_next == S_RUN);
            done      <= (state_next == S_RUN);
            case (state)
                S_GET_PC:   if (accept) start_pc <= in_data;
                S_GET_BASE: if (accept) addr_cnt <= in_data;
                S_GET_LEN:  if (accept) word_cnt <= in_data;
                S_GET_HI:   if (accept) hi_byte  <= in_data;
                S_GET_LO: begin
                    if (accept) begin
                        ram_addr   <= addr_cnt;
                        ram_wrdata <= {hi_byte, in_data};
                    end
                end
                S_WRITE: begin
                    addr_cnt <= addr_cnt + 8'd1;
                    word_cnt <= word_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Accumulator covers data bytes only and restarts on every accepted sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
            err <= 1'b0;
        end else begin
            err <= (state_next == S_ERROR);
            if (is_sync && (state == S_IDLE || state == S_RUN || state == S_ERROR))
                sum <= '0;
            else if (accept && (state == S_GET_HI || state == S_GET_LO))
                sum <= sum ^ in_data;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: frame-level write model plus directed literal checks.
// Adapts the frame format to PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        ram_wren;
    addr_t       ram_addr;
    word_t       ram_wrdata;
    logic [7:0]  start_pc;
    logic        cpu_rst_n;
    logic        done;
    logic        err;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          wr_count     = 0;
    logic [7:0]  last_addr    = '0;
    logic [15:0] last_data    = '0;
    logic [7:0]  exp_addr_q[$];
    logic [15:0] exp_data_q[$];

    always #5 clk = ~clk;

    prog_loader #(.SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .ram_wren   (ram_wren),
        .ram_addr   (ram_addr),
        .ram_wrdata (ram_wrdata),
        .start_pc   (start_pc),
        .cpu_rst_n  (cpu_rst_n),
        .done       (done),
        .err        (err)
    );

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs every cycle: handshake/status invariants and the expected write queue.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("ready_in_reset", 16'(in_ready), 16'd0);
            end else begin
                checkOutput("ready_vs_write", 16'(in_ready), 16'(!ram_wren));
                checkOutput("done_vs_cpu_rst_n", 16'(done), 16'(cpu_rst_n));
`ifndef PROG_LOADER_CHECKSUM_EN
                checkOutput("err_tied_low", 16'(err), 16'd0);
`endif
                if (ram_wren) begin
                    wr_count++;
                    last_addr = ram_addr;
                    last_data = ram_wrdata;
                    if (exp_addr_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                                 ram_addr, ram_wrdata);
                    end else begin
                        checkOutput("write_addr", 16'(ram_addr), 16'(exp_addr_q.pop_front()));
                        checkOutput("write_data", ram_wrdata, exp_data_q.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Returns just after the rising edge that consumed the byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int tries;
        idle(gap);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        tries    = 0;
        while (!in_ready && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL accept_timeout: got in_ready 0 for byte %h, expected 1", b);
        end
        @(posedge clk);
    endtask

    // Builds a frame from its fields, queues the writes it must cause, then streams it.
    task automatic applyStimulus(input logic [7:0] pc, input logic [7:0] base, input logic [7:0] len,
                                 input logic [15:0] w0, input logic [15:0] w1,
                                 input bit bad, input bit gaps, input bit skip_sync);
        logic [7:0]  bytes[$];
        logic [7:0]  sum = 8'h00;
        logic [15:0] w;
        if (!skip_sync) bytes.push_back(8'hA5);
        bytes.push_back(pc);
        bytes.push_back(base);
        bytes.push_back(len);
        for (int i = 0; i < int'(len); i++) begin
            w = (i == 0) ? w0 : w1;
            exp_addr_q.push_back(base + 8'(i));
            exp_data_q.push_back(w);
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
            sum = sum ^ w[15:8] ^ w[7:0];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        bytes.push_back(bad ? ~sum : sum);
`else
        if (bad) $display("[TB] checksum disabled, corrupt-sum frame sent without a sum byte");
`endif
        foreach (bytes[k]) send_byte(bytes[k], gaps ? (k % 6) : 0);
        idle(3);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_ram_wren"},   16'(ram_wren),  16'd0);
        checkOutput({tag, "_ram_addr"},   16'(ram_addr),  16'd0);
        checkOutput({tag, "_ram_wrdata"}, ram_wrdata,     16'd0);
        checkOutput({tag, "_start_pc"},   16'(start_pc),  16'd0);
        checkOutput({tag, "_cpu_rst_n"},  16'(cpu_rst_n), 16'd0);
        checkOutput({tag, "_done"},       16'(done),      16'd0);
        checkOutput({tag, "_err"},        16'(err),       16'd0);
    endtask

    task automatic run_all();
        int n;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // Garbage before sync, then the basic two-word image.
        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        applyStimulus(8'h04, 8'h04, 8'h02, 16'hF0D0, 16'h0F63, 1'b0, 1'b0, 1'b0);
        checkOutput("basic_start_pc", 16'(start_pc), 16'h0004);
        checkOutput("basic_cpu_rst_n", 16'(cpu_rst_n), 16'd1);
        checkOutput("basic_done", 16'(done), 16'd1);
        checkOutput("basic_err", 16'(err), 16'd0);
        checkOutput("basic_wr_count", 16'(wr_count), 16'd2);
        checkOutput("basic_last_addr", 16'(last_addr), 16'h0005);
        checkOutput("basic_last_data", last_data, 16'h0F63);

        // Reload from RUN with stalls.
        send_byte(8'hA5, 2);
        #1;
        checkOutput("reload_cpu_rst_n", 16'(cpu_rst_n), 16'd0);
        checkOutput("reload_done", 16'(done), 16'd0);
        applyStimulus(8'h08, 8'h40, 8'h02, 16'h1111, 16'h2222, 1'b0, 1'b1, 1'b1);
        checkOutput("reload_start_pc", 16'(start_pc), 16'h0008);
        checkOutput("reload_done_after", 16'(done), 16'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
        applyStimulus(8'h04, 8'h04, 8'h02, 16'hF0D0, 16'h0F63, 1'b1, 1'b0, 1'b0);
        checkOutput("badsum_err", 16'(err), 16'd1);
        checkOutput("badsum_cpu_rst_n", 16'(cpu_rst_n), 16'd0);
        checkOutput("badsum_done", 16'(done), 16'd0);
        send_byte(8'hA5, 0);
        #1;
        checkOutput("badsum_err_cleared", 16'(err), 16'd0);
        applyStimulus(8'h10, 8'hFF, 8'h02, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b1);
`else
        applyStimulus(8'h10, 8'hFF, 8'h02, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b0);
`endif
        checkOutput("wrap_last_addr", 16'(last_addr), 16'h0000);
        checkOutput("wrap_last_data", last_data, 16'hABCD);
        checkOutput("wrap_start_pc", 16'(start_pc), 16'h0010);
        checkOutput("wrap_cpu_rst_n", 16'(cpu_rst_n), 16'd1);

        n = wr_count;
        applyStimulus(8'h20, 8'h30, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        checkOutput("empty_no_writes", 16'(wr_count - n), 16'd0);
        checkOutput("empty_start_pc", 16'(start_pc), 16'h0020);
        checkOutput("empty_done", 16'(done), 16'd1);

        // Reset while waiting for the low byte must cancel the pending word.
        send_byte(8'hA5, 0);
        send_byte(8'h40, 0);
        send_byte(8'h50, 0);
        send_byte(8'h01, 0);
        send_byte(8'h77, 0);
        n = wr_count;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h88, 0);
        idle(5);
        checkOutput("midreset_no_write", 16'(wr_count - n), 16'd0);
        checkOutput("midreset_cpu_rst_n", 16'(cpu_rst_n), 16'd0);
        checkOutput("pending_writes", 16'(exp_addr_q.size()), 16'd0);
    endtask

    initial begin
        fork
            monitor();
            run_all();
        join_any
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
